nios_system_avalon_st_packet_arbiter_2to1: RTL and testbench

//   Packet-aware 2-to-1 Avalon-ST arbiter with round-robin grant and registered output.

---
 rtl/nios_system_avalon_st_packet_arbiter_2to1.sv | 171 +++++++++++++++++
 tb/tb_nios_system_avalon_st_packet_arbiter_2to1.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_avalon_st_packet_arbiter_2to1.sv
// Packet-aware 2-to-1 Avalon-ST arbiter with round-robin grant and a
// registered output stage. A grant is held from the first accepted beat
// through the accepted endofpacket beat, so packets never interleave.
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   in0_* / in1_*             Avalon-ST sinks (ready out; valid, data,
//                             error, startofpacket, endofpacket, empty in)
//   out_*                     registered Avalon-ST source (ready in)
//   out_channel               granted source index, registered; present
//                             only when ST_ARB_CHANNEL_EN is defined
module nios_system_avalon_st_packet_arbiter_2to1 #(
    parameter int DATA_W  = 32,
    parameter int ERR_W   = 6,
    parameter int EMPTY_W = 2
) (
    input  logic               clk,
    input  logic               reset_n,

    output logic               in0_ready,
    input  logic               in0_valid,
    input  logic [DATA_W-1:0]  in0_data,
    input  logic [ERR_W-1:0]   in0_error,
    input  logic               in0_startofpacket,
    input  logic               in0_endofpacket,
    input  logic [EMPTY_W-1:0] in0_empty,

    output logic               in1_ready,
    input  logic               in1_valid,
    input  logic [DATA_W-1:0]  in1_data,
    input  logic [ERR_W-1:0]   in1_error,
    input  logic               in1_startofpacket,
    input  logic               in1_endofpacket,
    input  logic [EMPTY_W-1:0] in1_empty,

    input  logic               out_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [ERR_W-1:0]   out_error,
    output logic               out_startofpacket,
    output logic               out_endofpacket,
`ifdef ST_ARB_CHANNEL_EN
    output logic               out_channel,
`endif
    output logic [EMPTY_W-1:0] out_empty
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_last;
    logic                 w_last_nxt;

    logic                 r_out_valid;
    logic [DATA_W-1:0]    r_out_data;
    logic [ERR_W-1:0]     r_out_error;
    logic                 r_out_sop;
    logic                 r_out_eop;
    logic [EMPTY_W-1:0]   r_out_empty;
`ifdef ST_ARB_CHANNEL_EN
    logic                 r_out_channel;
`endif

    logic                 w_slot_free;
    logic                 w_sel1;
    logic                 w_acc0;
    logic                 w_acc1;
    logic                 w_acc;
    logic [DATA_W-1:0]    w_data;
    logic [ERR_W-1:0]     w_error;
    logic                 w_sop;
    logic                 w_eop;
    logic [EMPTY_W-1:0]   w_empty;

    // The output register can take a beat when empty or draining this cycle.
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_sel1      = (r_state == S_GRANT1);
    assign w_acc0      = in0_valid && in0_ready;
    assign w_acc1      = in1_valid && in1_ready;
    assign w_acc       = w_acc0 || w_acc1;

    assign w_data  = w_sel1 ? in1_data          : in0_data;
    assign w_error = w_sel1 ? in1_error         : in0_error;
    assign w_sop   = w_sel1 ? in1_startofpacket : in0_startofpacket;
    assign w_eop   = w_sel1 ? in1_endofpacket   : in0_endofpacket;
    assign w_empty = w_sel1 ? in1_empty         : in0_empty;

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        in0_ready   = 1'b0;
        in1_ready   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // Both requesting: the source that did not go last wins.
                if (in0_valid && in1_valid) begin
                    w_state_nxt = r_last ? S_GRANT0 : S_GRANT1;
                end else if (in0_valid) begin
                    w_state_nxt = S_GRANT0;
                end else if (in1_valid) begin
                    w_state_nxt = S_GRANT1;
                end
            end
            S_GRANT0: begin
                in0_ready = w_slot_free;
                if (in0_valid && w_slot_free && in0_endofpacket) begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = 1'b0;
                end
            end
            S_GRANT1: begin
                in1_ready = w_slot_free;
                if (in1_valid && w_slot_free && in1_endofpacket) begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_error <= '0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_empty <= '0;
`ifdef ST_ARB_CHANNEL_EN
            r_out_channel <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            if (w_acc) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_data;
                r_out_error <= w_error;
                r_out_sop   <= w_sop;
                r_out_eop   <= w_eop;
                r_out_empty <= w_empty;
`ifdef ST_ARB_CHANNEL_EN
                r_out_channel <= w_sel1;
`endif
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid         = r_out_valid;
    assign out_data          = r_out_data;
    assign out_error         = r_out_error;
    assign out_startofpacket = r_out_sop;
    assign out_endofpacket   = r_out_eop;
    assign out_empty         = r_out_empty;
`ifdef ST_ARB_CHANNEL_EN
    assign out_channel       = r_out_channel;
`endif

endmodule

// File: tb/tb_nios_system_avalon_st_packet_arbiter_2to1.sv
// Testbench for nios_system_avalon_st_packet_arbiter_2to1.
// Directed scenarios plus a randomized run against a per-source scoreboard.
module tb_nios_system_avalon_st_packet_arbiter_2to1;

    typedef struct packed {
        logic [31:0] d;
        logic [5:0]  e;
        logic        s;
        logic        p;
        logic [1:0]  m;
        logic        ch;
    } beat_t;

`ifdef ST_ARB_CHANNEL_EN
    localparam bit CH_EN = 1'b1;
`else
    localparam bit CH_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in0_ready, in1_ready;
    logic        in0_valid = 1'b0, in1_valid = 1'b0;
    logic [31:0] in0_data = '0, in1_data = '0;
    logic [5:0]  in0_error = '0, in1_error = '0;
    logic        in0_startofpacket = 1'b0, in1_startofpacket = 1'b0;
    logic        in0_endofpacket = 1'b0, in1_endofpacket = 1'b0;
    logic [1:0]  in0_empty = '0, in1_empty = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [5:0]  out_error;
    logic        out_startofpacket, out_endofpacket;
    logic [1:0]  out_empty;
`ifdef ST_ARB_CHANNEL_EN
    logic        out_channel;
`endif

    nios_system_avalon_st_packet_arbiter_2to1 dut (
        .clk(clk), .reset_n(reset_n),
        .in0_ready(in0_ready), .in0_valid(in0_valid), .in0_data(in0_data),
        .in0_error(in0_error), .in0_startofpacket(in0_startofpacket),
        .in0_endofpacket(in0_endofpacket), .in0_empty(in0_empty),
        .in1_ready(in1_ready), .in1_valid(in1_valid), .in1_data(in1_data),
        .in1_error(in1_error), .in1_startofpacket(in1_startofpacket),
        .in1_endofpacket(in1_endofpacket), .in1_empty(in1_empty),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_error(out_error), .out_startofpacket(out_startofpacket),
        .out_endofpacket(out_endofpacket),
`ifdef ST_ARB_CHANNEL_EN
        .out_channel(out_channel),
`endif
        .out_empty(out_empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    beat_t q0[$], q1[$], obs[$];
    int    obs_cyc[$], acc0_cyc[$], acc1_cyc[$];
    bit    en0 = 1, en1 = 1, rdy = 1;
    bit    pres0 = 0, pres1 = 0, pv = 0, pr = 0;
    beat_t pb;
    int    cyc = 0, hold_viol = 0, both_rdy = 0, r1_seen = 0;

    function automatic beat_t mk(input logic [31:0] d, input bit s,
                                 input bit p, input bit src);
        beat_t b;
        b.d  = d;
        b.e  = d[5:0] ^ 6'h2a;
        b.s  = s;
        b.p  = p;
        b.m  = d[9:8];
        b.ch = CH_EN ? src : 1'b0;
        return b;
    endfunction

    function automatic beat_t out_beat();
        beat_t b;
        b.d  = out_data;
        b.e  = out_error;
        b.s  = out_startofpacket;
        b.p  = out_endofpacket;
        b.m  = out_empty;
`ifdef ST_ARB_CHANNEL_EN
        b.ch = out_channel;
`else
        b.ch = 1'b0;
`endif
        return b;
    endfunction

    task automatic clear_book();
        q0.delete(); q1.delete(); obs.delete(); obs_cyc.delete();
        acc0_cyc.delete(); acc1_cyc.delete();
        pres0 = 0; pres1 = 0; pv = 0; pr = 0; en0 = 1; en1 = 1; rdy = 1;
        cyc = 0; hold_viol = 0; both_rdy = 0; r1_seen = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        clear_book();
    endtask

    // One clock of traffic: drive queue heads, observe outputs, book handshakes.
    task automatic cycle();
        beat_t b0, b1, cur;
        @(negedge clk);
        b0 = '0; b1 = '0;
        if (q0.size() > 0) b0 = q0[0];
        if (q1.size() > 0) b1 = q1[0];
        in0_valid = (q0.size() > 0) && (pres0 || en0);
        in1_valid = (q1.size() > 0) && (pres1 || en1);
        in0_data = b0.d; in0_error = b0.e; in0_startofpacket = b0.s;
        in0_endofpacket = b0.p; in0_empty = b0.m;
        in1_data = b1.d; in1_error = b1.e; in1_startofpacket = b1.s;
        in1_endofpacket = b1.p; in1_empty = b1.m;
        out_ready = rdy;
        #1;
        cur = out_beat();
        if (pv && !pr && (!out_valid || cur !== pb)) hold_viol++;
        if (out_valid && out_ready) begin
            obs.push_back(cur);
            obs_cyc.push_back(cyc);
        end
        if (in0_ready && in1_ready) both_rdy++;
        if (in1_ready) r1_seen++;
        pres0 = in0_valid && !in0_ready;
        pres1 = in1_valid && !in1_ready;
        if (in0_valid && in0_ready) begin
            acc0_cyc.push_back(cyc);
            void'(q0.pop_front());
        end
        if (in1_valid && in1_ready) begin
            acc1_cyc.push_back(cyc);
            void'(q1.pop_front());
        end
        pv = out_valid; pr = out_ready; pb = cur;
        cyc++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0; in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL rst_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (out_data !== 32'h0 || out_error !== 6'h0 || out_empty !== 2'h0) begin
            failures++;
            $display("FAIL rst_payload got=%h/%h/%h exp=0", out_data, out_error, out_empty);
        end
        checks++;
        if (out_startofpacket !== 1'b0 || out_endofpacket !== 1'b0) begin
            failures++;
            $display("FAIL rst_sop_eop got=%b%b exp=00", out_startofpacket, out_endofpacket);
        end
        checks++;
        if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
            failures++; $display("FAIL rst_ready got=%b%b exp=00", in0_ready, in1_ready);
        end
`ifdef ST_ARB_CHANNEL_EN
        checks++;
        if (out_channel !== 1'b0) begin
            failures++; $display("FAIL rst_channel got=%b exp=0", out_channel);
        end
`endif
        reset_n = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0;
        clear_book();
    endtask

    task automatic test_single_source();
        beat_t exp[3];
        exp[0] = mk(32'hD000_0000, 1, 0, 0);
        exp[1] = mk(32'hD000_0101, 0, 0, 0);
        exp[2] = mk(32'hD000_0202, 0, 1, 0);
        do_reset();
        for (int k = 0; k < 3; k++) q0.push_back(exp[k]);
        cycle();
        checks++;
        if (in0_ready !== 1'b0) begin
            failures++; $display("FAIL t1_idle_ready got=%b exp=0", in0_ready);
        end
        repeat (7) cycle();
        checks++;
        if (obs.size() != 3) begin
            failures++; $display("FAIL t1_count got=%0d exp=3", obs.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp[k] || obs_cyc[k] != k + 2) begin
                    failures++;
                    $display("FAIL t1_beat%0d got=%h@%0d exp=%h@%0d",
                             k, obs[k], obs_cyc[k], exp[k], k + 2);
                end
            end
        end
        checks++;
        if (r1_seen != 0) begin
            failures++; $display("FAIL t1_in1_ready got=%0d exp=0", r1_seen);
        end
    endtask

    task automatic test_round_robin();
        beat_t ex[4];
        ex[0] = mk(32'hAAAA_0001, 1, 1, 0);
        ex[1] = mk(32'hBBBB_0102, 1, 1, 1);
        ex[2] = mk(32'hCCCC_0203, 1, 1, 0);
        ex[3] = mk(32'hDDDD_0304, 1, 1, 1);
        do_reset();
        q0.push_back(ex[0]); q1.push_back(ex[1]);
        for (int c = 0; c < 30 && obs.size() < 2; c++) cycle();
        q0.push_back(ex[2]); q1.push_back(ex[3]);
        for (int c = 0; c < 30 && obs.size() < 4; c++) cycle();
        checks++;
        if (obs.size() != 4) begin
            failures++; $display("FAIL t2_count got=%0d exp=4", obs.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs[k] !== ex[k]) begin
                    failures++; $display("FAIL t2_order%0d got=%h exp=%h", k, obs[k], ex[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        q0.push_back(mk(32'hA000_0001, 1, 0, 0));
        q0.push_back(mk(32'h1234_5678, 0, 0, 0));
        q0.push_back(mk(32'hA000_0203, 0, 1, 0));
        for (int c = 0; c < 10 && acc0_cyc.size() < 2; c++) cycle();
        rdy = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h1234_5678) begin
                failures++;
                $display("FAIL t3_hold%0d got=%b/%h exp=1/12345678", k, out_valid, out_data);
            end
            checks++;
            if (in0_ready !== 1'b0) begin
                failures++; $display("FAIL t3_ready%0d got=%b exp=0", k, in0_ready);
            end
        end
        rdy = 1;
        cycle();
        checks++;
        if (in0_ready !== 1'b1 || acc0_cyc.size() != 3) begin
            failures++;
            $display("FAIL t3_resume got=%b/%0d exp=1/3", in0_ready, acc0_cyc.size());
        end
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hA000_0203) begin
            failures++; $display("FAIL t3_next got=%b/%h exp=1/a0000203", out_valid, out_data);
        end
        checks++;
        if (hold_viol != 0) begin
            failures++; $display("FAIL t3_stable got=%0d exp=0", hold_viol);
        end
    endtask

    task automatic test_no_interleave();
        int e;
        do_reset();
        for (int k = 0; k < 4; k++)
            q0.push_back(mk(32'h0A00_0000 + 32'(k), k == 0, k == 3, 0));
        for (int c = 0; c < 10 && acc0_cyc.size() < 1; c++) cycle();
        q1.push_back(mk(32'h0B00_0000, 1, 0, 1));
        q1.push_back(mk(32'h0B00_0001, 0, 1, 1));
        for (int c = 0; c < 30 && obs.size() < 6; c++) cycle();
        checks++;
        if (obs.size() != 6 || acc0_cyc.size() != 4 || acc1_cyc.size() != 2) begin
            failures++;
            $display("FAIL t4_count got=%0d/%0d/%0d exp=6/4/2",
                     obs.size(), acc0_cyc.size(), acc1_cyc.size());
        end else begin
            e = acc0_cyc[3];
            checks++;
            if (acc1_cyc[0] != e + 2) begin
                failures++; $display("FAIL t4_in1_accept got=%0d exp=%0d", acc1_cyc[0], e + 2);
            end
            checks++;
            if (obs[3].d !== 32'h0A00_0003 || obs[4].d !== 32'h0B00_0000 ||
                obs_cyc[4] != obs_cyc[3] + 2) begin
                failures++;
                $display("FAIL t4_gap got=%h@%0d,%h@%0d exp=0a000003@n,0b000000@n+2",
                         obs[3].d, obs_cyc[3], obs[4].d, obs_cyc[4]);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        q0.push_back(mk(32'h5000_0000, 1, 1, 0));
        for (int c = 0; c < 10 && obs.size() < 1; c++) cycle();
        q1.push_back(mk(32'h6000_0000, 1, 0, 1));
        q1.push_back(mk(32'h6000_0101, 0, 0, 1));
        q1.push_back(mk(32'h6000_0202, 0, 1, 1));
        for (int c = 0; c < 10 && acc1_cyc.size() < 1; c++) cycle();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
            failures++;
            $display("FAIL t5_after_rst got=%b%b%b exp=000", out_valid, in0_ready, in1_ready);
        end
        clear_book();
        q0.push_back(mk(32'h7000_0000, 1, 1, 0));
        q1.push_back(mk(32'h8000_0000, 1, 1, 1));
        cycle();
        checks++;
        if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
            failures++; $display("FAIL t5_idle got=%b%b exp=00", in0_ready, in1_ready);
        end
        for (int c = 0; c < 20 && obs.size() < 2; c++) cycle();
        checks++;
        if (obs.size() != 2 || obs[0].d !== 32'h7000_0000) begin
            failures++;
            $display("FAIL t5_first_grant got=%0d/%h exp=2/70000000",
                     obs.size(), obs.size() > 0 ? obs[0].d : 32'h0);
        end
    endtask

    task automatic test_random();
        beat_t e0[$], e1[$], b, x;
        int total, len, shown;
        bit in_pkt, cur_src, src;
        do_reset();
        total = 0;
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < 10; p++) begin
                len = $urandom_range(1, 4);
                for (int k = 0; k < len; k++) begin
                    b.d  = {s[0], 31'($urandom)};
                    b.e  = 6'($urandom);
                    b.s  = (k == 0);
                    b.p  = (k == len - 1);
                    b.m  = 2'($urandom);
                    b.ch = CH_EN ? s[0] : 1'b0;
                    if (s == 0) begin q0.push_back(b); e0.push_back(b); end
                    else begin q1.push_back(b); e1.push_back(b); end
                    total++;
                end
            end
        end
        for (int c = 0; c < 3000 && obs.size() < total; c++) begin
            en0 = ($urandom_range(0, 3) != 0);
            en1 = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end
        checks++;
        if (obs.size() != total) begin
            failures++; $display("FAIL rnd_count got=%0d exp=%0d", obs.size(), total);
        end
        in_pkt = 0; cur_src = 0; shown = 0;
        foreach (obs[i]) begin
            src = obs[i].d[31];
            checks++;
            if (in_pkt && src != cur_src) begin
                failures++;
                if (shown++ < 5) $display("FAIL rnd_interleave beat=%0d got_src=%0d exp_src=%0d", i, src, cur_src);
            end
            x = '0;
            if (src && e1.size() > 0) x = e1.pop_front();
            else if (!src && e0.size() > 0) x = e0.pop_front();
            checks++;
            if (obs[i] !== x) begin
                failures++;
                if (shown++ < 5) $display("FAIL rnd_beat%0d got=%h exp=%h", i, obs[i], x);
            end
            in_pkt = !obs[i].p;
            cur_src = src;
        end
        checks++;
        if (hold_viol != 0 || both_rdy != 0) begin
            failures++;
            $display("FAIL rnd_protocol got=hold:%0d,both:%0d exp=0,0", hold_viol, both_rdy);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_no_interleave();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
